fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch controller that sequences the instruction decoder. It holds the program counter and issues single-word read requests to instruction memory over a request/grant/valid handshake. It captures each returned word and presents it to the decoder's memory-data input with a one-cycle read-enable strobe. It also handles downstream stall, control-flow redirect and halt, and sits between instruction memory and the decoder.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  level; leaves IDLE and begins fetching at current PC.
- halt_i  in  1  level; stop fetching at the next instruction boundary.
- stall_i  in  1  decoder/downstream cannot accept a new instruction this cycle.
- redirect_i  in  1  one-cycle pulse; replace PC with redirect_pc_i.
- redirect_pc_i  in  32  redirect target; bits [1:0] ignored (forced 0).
- mem_req_o  out  1  read request.
- mem_addr_o  out  32  word address of request (equals pc_o).
- mem_gnt_i  in  1  memory accepted request this cycle.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  32  read data, raw little-endian byte order (no swap here).
- instr_o  out  32  captured word, wired to decoder mem_data_i.
- dec_rd_en_o  out  1  strobe to decoder rd_en_i.
- pc_o  out  32  PC of the outstanding or presented instruction.
- busy_o  out  1  high in every state except IDLE.

## Operation
- States: IDLE, REQ, WAIT, ISSUE, DROP.
- IDLE: mem_req_o=0. If start_i=1 and halt_i=0, go to REQ.
- REQ: mem_req_o=1, mem_addr_o=pc. Hold until mem_gnt_i=1, then go to WAIT. If halt_i=1 and gnt=0, go to IDLE and cancel the request.
- WAIT: on mem_rvalid_i=1, register mem_rdata_i into instr_o, then go to ISSUE.
- ISSUE: dec_rd_en_o=1.
  - If stall_i=1, stay in ISSUE with instr_o and pc_o held and dec_rd_en_o held at 1; the decoder recaptures the same word.
  - If stall_i=0, set pc <= pc+4 and go to REQ, or to IDLE if halt_i=1.
- Redirect (any non-IDLE state; priority rst_i > redirect_i > halt_i > normal):
  - pc <= {redirect_pc_i[31:2],2'b00}.
  - From REQ with gnt=0: go to REQ and issue the new address next cycle.
  - From REQ with gnt=1, or from WAIT with rvalid=0: go to DROP, because a response is still owed.
  - From WAIT with rvalid=1: discard the data, go to REQ.
  - From ISSUE: go to REQ; the strobe is not extended and no pc+4 increment occurs.
  - From DROP: update pc, remain in DROP.
- DROP: mem_req_o=0, dec_rd_en_o=0. Wait for mem_rvalid_i, discard the data, then go to REQ (or IDLE if halt_i=1).
- redirect_i in IDLE: updates pc only.
- PC arithmetic: unsigned 32-bit. 32'hFFFF_FFFC+4 wraps to 32'h0000_0000.
- One outstanding request maximum. mem_req_o is never asserted in WAIT, ISSUE or DROP.
- The memory protocol requires mem_rvalid_i to arrive no earlier than the cycle after mem_gnt_i. mem_rvalid_i in IDLE, REQ or ISSUE is ignored.

## Timing
- Reset (rst_i=1 at a clock edge) from any state:
  - State goes to IDLE, pc=RESET_PC, instr_o=0.
  - mem_req_o=0, dec_rd_en_o=0, busy_o=0.
  - Any in-flight response is abandoned. Memory must be reset alongside.
- All outputs are registered or decoded from registered state; there is no combinational input-to-output path.
- Zero-wait memory (gnt in REQ cycle, rvalid next cycle):
  - Cycle N: REQ.
  - Cycle N+1: WAIT, rvalid.
  - Cycle N+2: ISSUE (dec_rd_en_o=1).
  - Cycle N+3: REQ at pc+4.
  - Throughput is 1 instruction / 3 cycles.
- start_i sampled in cycle N gives mem_req_o=1 in N+1.
- The decoder registers its outputs on the edge ending the ISSUE cycle. Decoded fields are therefore valid one cycle after dec_rd_en_o.
- Redirect in cycle N gives mem_addr_o=target in N+1, unless a drop is needed. In that case the target is requested the cycle after the dropped rvalid.

## Test plan
- Reset, start, zero-wait memory returning 32'h1300_0000 at 0x0, 0x4, 0x8 -> mem_addr_o sequence 0x0, 0x4, 0x8. dec_rd_en_o pulses every 3rd cycle with instr_o=32'h1300_0000 and pc_o matching.
- Grant delayed 3 cycles and rvalid delayed 2 cycles after grant -> mem_req_o held with stable address for 4 cycles. Exactly one dec_rd_en_o pulse; pc advances by 4.
- stall_i high for 5 cycles during ISSUE at pc 0x10 -> dec_rd_en_o high for 6 cycles with instr_o/pc_o constant. Next request at address 0x14.
- redirect_i to 32'h0000_0103 in the same cycle as mem_gnt_i -> state goes to DROP; the following rvalid data is not forwarded (no dec_rd_en_o). Next request address is 32'h0000_0100.
- PC 32'hFFFF_FFFC issued, stall_i=0 -> next mem_addr_o=32'h0000_0000.
- rst_i asserted in WAIT, then rvalid arrives -> outputs at reset values, no strobe, busy_o=0. After start_i, the first request is at RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC holder and single-outstanding instruction fetch sequencer feeding the decoder
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        halt_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] instr_o,
    output logic        dec_rd_en_o,
    output logic [31:0] pc_o,
    output logic        busy_o
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, ISSUE, DROP} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d, target;
    assign target      = {redirect_pc_i[31:2], 2'b00};
    assign mem_req_o   = state_q == REQ;
    assign mem_addr_o  = pc_q;
    assign pc_o        = pc_q;
    assign instr_o     = instr_q;
    assign dec_rd_en_o = state_q == ISSUE;
    assign busy_o      = state_q != IDLE;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            IDLE: begin
                if (redirect_i) pc_d = target;
                if (start_i && !halt_i) state_d = REQ;
            end
            REQ: begin
                if (redirect_i) begin
                    pc_d    = target;
                    state_d = mem_gnt_i ? DROP : REQ;
                end else if (mem_gnt_i) state_d = WAIT;
                else if (halt_i) state_d = IDLE;
            end
            WAIT: begin
                if (redirect_i) begin
                    pc_d    = target;
                    state_d = mem_rvalid_i ? REQ : DROP;
                end else if (mem_rvalid_i) begin
                    instr_d = mem_rdata_i;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (redirect_i) begin
                    pc_d    = target;
                    state_d = REQ;
                end else if (!stall_i) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = halt_i ? IDLE : REQ;
                end
            end
            DROP: begin
                // a redirect coinciding with the owed response must not strand us here
                if (redirect_i) pc_d = target;
                if (mem_rvalid_i) state_d = halt_i ? IDLE : REQ;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboard bench with a delay-configurable memory model
module tb_fetch_sequencer;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1, start_i = 1'b0, halt_i = 1'b0, stall_i = 1'b0, redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        mem_req_o, mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [31:0] mem_addr_o, mem_rdata_i = 32'h0, instr_o, pc_o;
    logic        dec_rd_en_o, busy_o;
    int          n_cmp = 0, n_err = 0;
    logic [63:0] exp_q[$];
    bit          prev_en = 1'b0, pending = 1'b0, use_const = 1'b1;
    int          gnt_dly = 0, rv_dly = 0, req_cnt = 0, rv_cnt = 0;
    logic [31:0] paddr = 32'h0;

    always #5 clk_i = ~clk_i;

    fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .halt_i(halt_i), .stall_i(stall_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .mem_req_o(mem_req_o),
        .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .instr_o(instr_o), .dec_rd_en_o(dec_rd_en_o),
        .pc_o(pc_o), .busy_o(busy_o)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return use_const ? 32'h1300_0000 : a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic cyc();
        logic [63:0] e;
        @(negedge clk_i);
        if (dec_rd_en_o && !prev_en) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL strobe_unexpected: got pc=%h instr=%h, required no strobe", pc_o, instr_o);
            end else begin
                e = exp_q.pop_front();
                if ({pc_o, instr_o} !== e) begin
                    n_err++;
                    $display("FAIL strobe_data: got pc=%h instr=%h, required pc=%h instr=%h", pc_o, instr_o, e[63:32], e[31:0]);
                end
            end
        end
        prev_en = dec_rd_en_o;
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0;
        if (pending) begin
            if (rv_cnt == rv_dly) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i = word(paddr);
                pending = 1'b0;
            end else rv_cnt++;
        end else if (mem_req_o) begin
            if (req_cnt == gnt_dly) begin
                mem_gnt_i = 1'b1;
                paddr = mem_addr_o;
                pending = 1'b1;
                rv_cnt = 0;
                req_cnt = 0;
            end else req_cnt++;
        end else req_cnt = 0;
    endtask

    task automatic wait_strobe();
        for (int i = 0; i < 40 && !dec_rd_en_o; i++) cyc();
    endtask

    task automatic halt_stop();
        halt_i = 1'b1;
        cyc();
        halt_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        cyc();
        cyc();
        rst_i = 1'b0;
        cyc();
        n_cmp++;
        if ({mem_req_o, dec_rd_en_o, busy_o, pc_o, mem_addr_o, instr_o} !== {3'b000, 96'h0}) begin
            n_err++;
            $display("FAIL reset_state: got req=%b en=%b busy=%b pc=%h instr=%h, required all zero", mem_req_o, dec_rd_en_o, busy_o, pc_o, instr_o);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] addrs[$];
        int strc[$];
        int t = 1;
        use_const = 1'b1; gnt_dly = 0; rv_dly = 0;
        for (int i = 0; i < 3; i++) exp_q.push_back({32'(i * 4), 32'h1300_0000});
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        for (int i = 0; i < 20 && busy_o; i++) begin
            if (mem_req_o) addrs.push_back(mem_addr_o);
            if (dec_rd_en_o) begin
                strc.push_back(t);
                if (strc.size() == 3) halt_i = 1'b1;
            end
            cyc();
            t++;
        end
        halt_i = 1'b0;
        n_cmp++;
        if (addrs.size() != 3 || addrs[0] !== 32'h0 || addrs[1] !== 32'h4 || addrs[2] !== 32'h8) begin
            n_err++;
            $display("FAIL zw_addr_seq: got %p, required 0,4,8", addrs);
        end
        n_cmp++;
        if (strc.size() != 3 || strc[0] != 3 || strc[1] != 6 || strc[2] != 9) begin
            n_err++;
            $display("FAIL zw_strobe_cycles: got %p, required 3,6,9", strc);
        end
        n_cmp++;
        if ({busy_o, pc_o} !== {1'b0, 32'hC} || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL zw_end: got busy=%b pc=%h pending=%0d, required busy=0 pc=c pending=0", busy_o, pc_o, exp_q.size());
        end
    endtask

    task automatic test_delayed();
        int nreq = 0, nstr = 0;
        bit moved = 1'b0;
        use_const = 1'b0; gnt_dly = 3; rv_dly = 1;
        exp_q.push_back({32'hC, word(32'hC)});
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        for (int i = 0; i < 20 && busy_o; i++) begin
            if (mem_req_o) begin
                nreq++;
                if (mem_addr_o !== 32'hC) moved = 1'b1;
            end
            if (dec_rd_en_o) begin
                nstr++;
                halt_i = 1'b1;
            end
            cyc();
        end
        halt_i = 1'b0;
        n_cmp++;
        if (nreq != 4 || moved) begin
            n_err++;
            $display("FAIL dly_req_hold: got %0d req cycles moved=%b, required 4 stable", nreq, moved);
        end
        n_cmp++;
        if (nstr != 1 || pc_o !== 32'h10 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL dly_end: got strobes=%0d pc=%h pending=%0d, required 1 pc=10 pending=0", nstr, pc_o, exp_q.size());
        end
    endtask

    task automatic test_stall();
        int nhi;
        gnt_dly = 0; rv_dly = 0;
        exp_q.push_back({32'h10, word(32'h10)});
        exp_q.push_back({32'h14, word(32'h14)});
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        wait_strobe();
        nhi = dec_rd_en_o ? 1 : 0;
        stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_cmp++;
            if ({dec_rd_en_o, pc_o, instr_o} !== {1'b1, 32'h10, word(32'h10)}) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got en=%b pc=%h instr=%h, required en=1 pc=10 instr=%h", i, dec_rd_en_o, pc_o, instr_o, word(32'h10));
            end else nhi++;
        end
        stall_i = 1'b0;
        cyc();
        n_cmp++;
        if (nhi != 6 || dec_rd_en_o !== 1'b0) begin
            n_err++;
            $display("FAIL stall_len: got %0d high cycles en_after=%b, required 6 then 0", nhi, dec_rd_en_o);
        end
        n_cmp++;
        if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h14}) begin
            n_err++;
            $display("FAIL stall_next_req: got req=%b addr=%h, required req=1 addr=14", mem_req_o, mem_addr_o);
        end
        wait_strobe();
        halt_stop();
        n_cmp++;
        if ({busy_o, pc_o} !== {1'b0, 32'h18} || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL stall_end: got busy=%b pc=%h pending=%0d, required busy=0 pc=18 pending=0", busy_o, pc_o, exp_q.size());
        end
    endtask

    task automatic test_redirect();
        gnt_dly = 0; rv_dly = 1;
        exp_q.push_back({32'h100, word(32'h100)});
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        n_cmp++;
        if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h18}) begin
            n_err++;
            $display("FAIL redir_req: got req=%b addr=%h, required req=1 addr=18", mem_req_o, mem_addr_o);
        end
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0103;
        cyc();
        redirect_i = 1'b0;
        n_cmp++;
        if ({mem_req_o, dec_rd_en_o, busy_o, pc_o} !== {3'b001, 32'h100}) begin
            n_err++;
            $display("FAIL redir_drop: got req=%b en=%b busy=%b pc=%h, required 0 0 1 pc=100", mem_req_o, dec_rd_en_o, busy_o, pc_o);
        end
        cyc();
        cyc();
        n_cmp++;
        if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h100}) begin
            n_err++;
            $display("FAIL redir_target_req: got req=%b addr=%h, required req=1 addr=100", mem_req_o, mem_addr_o);
        end
        wait_strobe();
        halt_stop();
        n_cmp++;
        if ({busy_o, pc_o} !== {1'b0, 32'h104} || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL redir_end: got busy=%b pc=%h pending=%0d, required busy=0 pc=104 pending=0", busy_o, pc_o, exp_q.size());
        end
    endtask

    task automatic test_wrap();
        gnt_dly = 0; rv_dly = 0;
        redirect_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFF;
        cyc();
        redirect_i = 1'b0;
        n_cmp++;
        if ({busy_o, pc_o} !== {1'b0, 32'hFFFF_FFFC}) begin
            n_err++;
            $display("FAIL wrap_idle_redirect: got busy=%b pc=%h, required busy=0 pc=fffffffc", busy_o, pc_o);
        end
        exp_q.push_back({32'hFFFF_FFFC, word(32'hFFFF_FFFC)});
        exp_q.push_back({32'h0, word(32'h0)});
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        wait_strobe();
        cyc();
        n_cmp++;
        if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h0}) begin
            n_err++;
            $display("FAIL wrap_next_req: got req=%b addr=%h, required req=1 addr=0", mem_req_o, mem_addr_o);
        end
        wait_strobe();
        halt_stop();
        n_cmp++;
        if ({busy_o, pc_o} !== {1'b0, 32'h4} || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL wrap_end: got busy=%b pc=%h pending=%0d, required busy=0 pc=4 pending=0", busy_o, pc_o, exp_q.size());
        end
    endtask

    task automatic test_halt_req();
        gnt_dly = 5;
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        halt_i = 1'b1;
        cyc();
        halt_i = 1'b0;
        n_cmp++;
        if ({mem_req_o, busy_o, pc_o} !== {2'b00, 32'h4}) begin
            n_err++;
            $display("FAIL halt_in_req: got req=%b busy=%b pc=%h, required 0 0 pc=4", mem_req_o, busy_o, pc_o);
        end
    endtask

    task automatic test_reset_wait();
        gnt_dly = 0; rv_dly = 2;
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        cyc();
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({mem_req_o, dec_rd_en_o, busy_o, pc_o, instr_o} !== {3'b000, 64'h0}) begin
                n_err++;
                $display("FAIL rst_wait[%0d]: got req=%b en=%b busy=%b pc=%h instr=%h, required all zero", i, mem_req_o, dec_rd_en_o, busy_o, pc_o, instr_o);
            end
            cyc();
        end
        rv_dly = 0;
        exp_q.push_back({32'h0, word(32'h0)});
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        n_cmp++;
        if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h0}) begin
            n_err++;
            $display("FAIL rst_first_req: got req=%b addr=%h, required req=1 addr=0", mem_req_o, mem_addr_o);
        end
        wait_strobe();
        halt_stop();
        n_cmp++;
        if (exp_q.size() != 0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL rst_end: got pending=%0d busy=%b, required 0 0", exp_q.size(), busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_delayed();
        test_stall();
        test_redirect();
        test_wrap();
        test_halt_req();
        test_reset_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
